hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Tracks the destination register and remaining result latency
//             (Tnew) of the instructions in E, M and W, and resolves the
//             D-stage operands into a stall request and forwarding selects.
//  Config   : HAZARD_FWD_EN -- defined: forwarding from E/M/W with
//             Tnew/Tuse stall rules; undefined: no forwarding, stall on any
//             E/M producer.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_tnew,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel
);

    localparam logic [1:0] C_SEL_RF    = 2'd0;
    localparam logic [1:0] C_SEL_E     = 2'd1;
    localparam logic [1:0] C_SEL_M     = 2'd2;
    localparam logic [1:0] C_SEL_W     = 2'd3;
    localparam logic [1:0] C_TUSE_NONE = 2'd3;

    logic       r_e_valid, r_m_valid, r_w_valid;
    logic [4:0] r_e_a3,    r_m_a3,    r_w_a3;
    logic [1:0] r_e_tnew,  r_m_tnew,  r_w_tnew;

    logic [2:0] w_rs_res;   // {stall_request, select}
    logic [2:0] w_rt_res;

    // Saturating decrement applied each time an entry moves one stage on,
    // including the move from D into E, so an ALU result sitting in E is
    // already forwardable (Tnew 0) and a load becomes forwardable from M.
    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        dec_sat = (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Find the youngest matching producer for one source operand and turn it
    // into a stall request and an operand select.
    function automatic logic [2:0] resolve(input logic [4:0] r, input logic [1:0] tuse);
        logic       live;
        logic [1:0] code;
        logic       req;
        logic [1:0] sel;
`ifdef HAZARD_FWD_EN
        logic [1:0] tnew;
`endif
        live = (r != 5'd0) && (tuse != C_TUSE_NONE);
        code = C_SEL_RF;
        if (live && r_e_valid && (r_e_a3 == r))
            code = C_SEL_E;
        else if (live && r_m_valid && (r_m_a3 == r))
            code = C_SEL_M;
        else if (live && r_w_valid && (r_w_a3 == r))
            code = C_SEL_W;
`ifdef HAZARD_FWD_EN
        case (code)
            C_SEL_E: tnew = r_e_tnew;
            C_SEL_M: tnew = r_m_tnew;
            C_SEL_W: tnew = r_w_tnew;
            default: tnew = 2'd0;
        endcase
        req = (code != C_SEL_RF) && (tnew > tuse);
        sel = ((code != C_SEL_RF) && (tnew == 2'd0)) ? code : C_SEL_RF;
`else
        // Without forwarding the value is only usable once it reaches the
        // write-through register file, i.e. when the producer is in W.
        req = (code == C_SEL_E) || (code == C_SEL_M);
        sel = C_SEL_RF;
`endif
        resolve = {req, sel};
    endfunction

    // Advance the slot pipeline; a stall turns the entry into E into a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_valid <= 1'b0; r_e_a3 <= 5'd0; r_e_tnew <= 2'd0;
            r_m_valid <= 1'b0; r_m_a3 <= 5'd0; r_m_tnew <= 2'd0;
            r_w_valid <= 1'b0; r_w_a3 <= 5'd0; r_w_tnew <= 2'd0;
        end else begin
            r_w_valid <= r_m_valid;
            r_w_a3    <= r_m_a3;
            r_w_tnew  <= dec_sat(r_m_tnew);
            r_m_valid <= r_e_valid;
            r_m_a3    <= r_e_a3;
            r_m_tnew  <= dec_sat(r_e_tnew);
            if (stall) begin
                r_e_valid <= 1'b0;
                r_e_a3    <= 5'd0;
                r_e_tnew  <= 2'd0;
            end else begin
                r_e_valid <= d_valid;
                r_e_a3    <= d_a3;
                r_e_tnew  <= dec_sat(d_tnew);
            end
        end
    end

    // Resolve both D-stage sources against the current slot contents.
    always_comb begin
        w_rs_res = resolve(d_rs, d_tuse_rs);
        w_rt_res = resolve(d_rt, d_tuse_rt);
    end

    assign stall = d_valid & (w_rs_res[2] | w_rt_res[2]);

`ifdef HAZARD_FWD_EN
    assign fwd_rs_sel = w_rs_res[1:0];
    assign fwd_rt_sel = w_rt_res[1:0];
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{w_rs_res[1:0], w_rt_res[1:0], r_e_tnew, r_m_tnew, r_w_tnew};
    assign fwd_rs_sel = C_SEL_RF;
    assign fwd_rt_sel = C_SEL_RF;
`endif

endmodule
`default_nettype wire
